univ_shift_reg: RTL and testbench

//  Parametrised universal shift register: the multi-bit successor to the single D flip-flop.

---
 rtl/univ_shift_reg.sv | 94 +++++++++
 tb/tb_univ_shift_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/clear/shift/rotate/ASR on a WIDTH-bit word,
// with a burst mode that repeats one operation amt times under start/busy/done.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [2:0]       mode_l;
    logic [CNT_W-1:0] cnt;

    function automatic logic [WIDTH-1:0] op(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] dv,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        r = cur;
        unique case (m)
            3'd0: r = cur;
            3'd1: r = dv;
            3'd2: r = '0;
            3'd3: r = {cur[WIDTH-2:0], sr};
            3'd4: r = {sl, cur[WIDTH-1:1]};
            3'd5: r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            3'd6: r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'd7: r = {cur[0], cur[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            state  <= IDLE;
            mode_l <= 3'd0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_l <= mode;
                        cnt    <= amt;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else if (en) begin
                        q <= op(mode, q, d, sin_l, sin_r);
                    end
                end
                RUN: begin
                    // amt=0 still spends one RUN edge, but applies no op
                    if (cnt != '0) begin
                        q   <= op(mode_l, q, d, sin_l, sin_r);
                        cnt <= cnt - CNT_W'(1);
                    end
                    if (cnt == '0 || cnt == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: single-step vector table plus
// hand-written burst, reset and start-while-busy sequences.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic       start;
    logic [3:0] amt;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;
    int ndone;

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sin_l;
        logic       sin_r;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[13];

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .start(start), .amt(amt),
        .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string nm, input logic [7:0] eq,
                          input logic eb, input logic ed);
        chk({nm, ".q"}, 32'(q), 32'(eq));
        chk({nm, ".busy"}, 32'(busy), 32'(eb));
        chk({nm, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic load(input logic [7:0] v);
        en = 1'b1; mode = 3'd1; d = v;
        step();
        en = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd1, 8'hA5, 1'b0, 1'b0, 8'hA5};
        vecs[1]  = '{1'b1, 3'd3, 8'h00, 1'b0, 1'b1, 8'h4B};
        vecs[2]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 1'b1, 8'h4B};
        vecs[3]  = '{1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 8'hA5};
        vecs[4]  = '{1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'h4B};
        vecs[5]  = '{1'b1, 3'd1, 8'h90, 1'b0, 1'b0, 8'h90};
        vecs[6]  = '{1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'hC8};
        vecs[7]  = '{1'b1, 3'd1, 8'h90, 1'b0, 1'b0, 8'h90};
        vecs[8]  = '{1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h48};
        vecs[9]  = '{1'b1, 3'd4, 8'h00, 1'b1, 1'b0, 8'hA4};
        vecs[10] = '{1'b1, 3'd3, 8'h00, 1'b1, 1'b0, 8'h48};
        vecs[11] = '{1'b1, 3'd2, 8'hFF, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 3'd1, 8'hFF, 1'b0, 1'b0, 8'h00};

        reset = 1'b1; en = 1'b0; mode = 3'd0; d = 8'h00;
        sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; amt = 4'd0;
        #12;
        chk_st("reset", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 13; i++) begin
            en = vecs[i].en; mode = vecs[i].mode; d = vecs[i].d;
            sin_l = vecs[i].sin_l; sin_r = vecs[i].sin_r;
            step();
            chk($sformatf("vec%0d.q", i), 32'(q), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d.sl", i), 32'(sout_l), 32'(vecs[i].exp_q[7]));
            chk($sformatf("vec%0d.sr", i), 32'(sout_r), 32'(vecs[i].exp_q[0]));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(0));
        end
        en = 1'b0; sin_l = 1'b0; sin_r = 1'b0;

        // asynchronous reset mid-cycle
        load(8'hFF);
        chk("pre_rst.q", 32'(q), 32'hFF);
        #2 reset = 1'b1;
        #1 chk_st("async_rst", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;

        // burst ROR x3, mode/d changes ignored while busy
        load(8'hA5);
        start = 1'b1; mode = 3'd7; amt = 4'd3;
        step();
        chk_st("ror.acc", 8'hA5, 1'b1, 1'b0);
        start = 1'b0; mode = 3'd1; d = 8'h00; amt = 4'd9;
        step(); chk_st("ror.1", 8'hD2, 1'b1, 1'b0);
        step(); chk_st("ror.2", 8'h69, 1'b1, 1'b0);
        step(); chk_st("ror.3", 8'hB4, 1'b0, 1'b1);
        step(); chk_st("ror.after", 8'hB4, 1'b0, 1'b0);

        // amt=0: no op, done after two edges
        start = 1'b1; mode = 3'd2; amt = 4'd0;
        step(); chk_st("z.acc", 8'hB4, 1'b1, 1'b0);
        start = 1'b0;
        step(); chk_st("z.done", 8'hB4, 1'b0, 1'b1);
        step(); chk_st("z.after", 8'hB4, 1'b0, 1'b0);

        // start and en during burst ignored; back-to-back start in done cycle
        start = 1'b1; mode = 3'd6; amt = 4'd2;
        step(); chk_st("bb.acc", 8'hB4, 1'b1, 1'b0);
        mode = 3'd2; amt = 4'd5; en = 1'b1;
        step(); chk_st("bb.1", 8'h69, 1'b1, 1'b0);
        start = 1'b0; en = 1'b0;
        step(); chk_st("bb.2", 8'hD2, 1'b0, 1'b1);
        start = 1'b1; mode = 3'd7; amt = 4'd1;
        step(); chk_st("bb.acc2", 8'hD2, 1'b1, 1'b0);
        start = 1'b0;
        step(); chk_st("bb.3", 8'h69, 1'b0, 1'b1);
        step(); chk_st("bb.after", 8'h69, 1'b0, 1'b0);

        // reset mid-burst after 4 ops, then normal restart
        load(8'h00);
        start = 1'b1; mode = 3'd3; sin_r = 1'b1; amt = 4'd10;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk_st("mb.4ops", 8'h0F, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 chk_st("mb.rst", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) ndone++;
        end
        chk("mb.no_done", 32'(ndone), 32'(0));
        chk("mb.q_idle", 32'(q), 32'h00);
        start = 1'b1; mode = 3'd1; d = 8'h3C; amt = 4'd1;
        step(); chk_st("mb.acc", 8'h00, 1'b1, 1'b0);
        start = 1'b0;
        step(); chk_st("mb.load", 8'h3C, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
